// File: rtl/poly_sqnorm_pkg.sv
// Shared definitions for the polynomial squared-norm bound checker.
// Holds the job FSM state type, the Falcon signature bound constants and
// constant functions that size the beat counter and the adder datapath.
package poly_sqnorm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Squared-norm acceptance bounds for Falcon-512 and Falcon-1024.
  localparam logic [31:0] FALCON512_BOUND  = 32'd34034726;
  localparam logic [31:0] FALCON1024_BOUND = 32'd70265242;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Number of accepted beats that make up one job.
  function automatic int beat_count(input int logn, input int npoly, input int lanes);
    return (npoly << logn) / lanes;
  endfunction

  // Width of one lane square: the largest square is 2^(2*COEF_W-2).
  function automatic int sq_width(input int coef_w);
    return 2 * coef_w - 1;
  endfunction

  // Width of the per-beat lane sum.
  function automatic int sum_width(input int coef_w, input int lanes);
    return sq_width(coef_w) + clog2_int(lanes);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Falcon bound for a given log2 degree; zero for unsupported degrees.
  function automatic logic [31:0] falcon_bound(input int logn);
    logic [31:0] b;
    case (logn)
      9:       b = FALCON512_BOUND;
      10:      b = FALCON1024_BOUND;
      default: b = 32'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/poly_sqnorm_bound_lane_tree.sv
// sqnorm_lane_tree: pipeline stages 1 and 2 of the squared-norm datapath.
// Stage 1 registers the unsigned square of every lane, stage 2 registers the
// sum over all lanes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of both stage valids (job abort)
//   in_valid     beat accepted this cycle
//   f            LANES signed COEF_W-bit coefficients, lane 0 in the LSBs
//   out_valid    stage-2 result valid
//   out_sum      sum of the lane squares for one beat
module sqnorm_lane_tree
  import poly_sqnorm_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int COEF_W = 16,
  localparam int SQ_W  = sq_width(COEF_W),
  localparam int SUM_W = sum_width(COEF_W, LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [LANES*COEF_W-1:0]   f,
  output logic                      out_valid,
  output logic [SUM_W-1:0]          out_sum
);

  logic [SQ_W-1:0]  sq_s [LANES];
  logic [SQ_W-1:0]  sq_r [LANES];
  logic             v1_r;
  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] sum_r;
  logic             v2_r;

  // Squaring the magnitude avoids a signed multiply. The magnitude of the
  // most negative code is 2^(COEF_W-1), which still fits unsigned in COEF_W
  // bits, so its square 2^(2*COEF_W-2) comes out exactly with no wrap.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [COEF_W-1:0] coef_s;
    logic [COEF_W-1:0] mag_s;
    assign coef_s  = f[i*COEF_W +: COEF_W];
    assign mag_s   = coef_s[COEF_W-1] ? (~coef_s + {{(COEF_W-1){1'b0}}, 1'b1}) : coef_s;
    assign sq_s[i] = SQ_W'(mag_s) * SQ_W'(mag_s);
  end

  // Lane-sum tree over the registered squares.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + SUM_W'(sq_r[i]);
    end
  end

  // Stage 1 and stage 2 registers; data only loads when its valid is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_r  <= '{default: '0};
      v1_r  <= 1'b0;
      sum_r <= '0;
      v2_r  <= 1'b0;
    end else if (flush) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        sq_r <= sq_s;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        sum_r <= sum_s;
      end
    end
  end

  assign out_valid = v2_r;
  assign out_sum   = sum_r;

endmodule

// File: rtl/poly_sqnorm_bound.sv
// poly_sqnorm_bound: streams NPOLY polynomials of 2^LOGN signed coefficients,
// LANES per beat, accumulates the sum of squares with saturation and checks
// it against a bound latched at job start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          rising edge in IDLE starts a job; low during a job aborts it
//   bound        unsigned squared-norm bound, latched on the start cycle
//   f_valid, f   coefficient beat, lane 0 in the LSBs
//   busy         job in ACCUM or DRAIN
//   s_valid      one-cycle result strobe
//   s            saturated squared norm, held until the next completed job
//   s_ok         no overflow and s <= bound
//   s_ovf        accumulator saturated during the job
module poly_sqnorm_bound
  import poly_sqnorm_pkg::*;
#(
  parameter int LOGN   = 9,
  parameter int COEF_W = 16,
  parameter int LANES  = 4,
  parameter int NPOLY  = 2,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [ACC_W-1:0]         bound,
  input  logic                     f_valid,
  input  logic [LANES*COEF_W-1:0]  f,
  output logic                     busy,
  output logic                     s_valid,
  output logic [ACC_W-1:0]         s,
  output logic                     s_ok,
  output logic                     s_ovf
);

  localparam int BEATS = beat_count(LOGN, NPOLY, LANES);
  localparam int CNT_W = max_int(clog2_int(BEATS), 1);
  localparam int SUM_W = sum_width(COEF_W, LANES);
  localparam int EXT_W = max_int(ACC_W, SUM_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           state_r;
  state_e           state_s;
  logic             ena_r;
  logic [ACC_W-1:0] bound_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       drain_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             busy_r;
  logic             s_valid_r;
  logic [ACC_W-1:0] s_r;
  logic             s_ok_r;
  logic             s_ovf_r;

  logic             start_s;
  logic             accept_s;
  logic             last_s;
  logic             abort_s;
  logic             finish_s;
  logic             tree_valid_s;
  logic [SUM_W-1:0] tree_sum_s;
  logic [EXT_W-1:0] ext_s;
  logic             carry_s;

  assign start_s  = (state_r == IDLE) && ena && !ena_r;
  assign accept_s = (state_r == ACCUM) && ena && f_valid;
  assign last_s   = accept_s && (cnt_r == LAST_BEAT);
  assign abort_s  = ((state_r == ACCUM) || (state_r == DRAIN)) && !ena;
  assign finish_s = (state_r == DRAIN) && (state_s == DONE);

  sqnorm_lane_tree #(
    .LANES  (LANES),
    .COEF_W (COEF_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_s),
    .in_valid  (accept_s),
    .f         (f),
    .out_valid (tree_valid_s),
    .out_sum   (tree_sum_s)
  );

  // The add is done one bit wider than either operand so any carry out of
  // ACC_W bits is visible as a nonzero upper part.
  assign ext_s   = EXT_W'(acc_r) + EXT_W'(tree_sum_s);
  assign carry_s = (ext_s >> ACC_W) != '0;

  // Next-state logic. DRAIN waits out the two tree stages plus the
  // accumulator update before DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = ACCUM;
        else         state_s = IDLE;
      end
      ACCUM: begin
        if (!ena)        state_s = IDLE;
        else if (last_s) state_s = DRAIN;
        else             state_s = ACCUM;
      end
      DRAIN: begin
        if (!ena)                 state_s = IDLE;
        else if (drain_r == 2'd2) state_s = DONE;
        else                      state_s = DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, edge detect, bound latch, beat and drain counters, busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ena_r   <= 1'b0;
      bound_r <= '0;
      cnt_r   <= '0;
      drain_r <= 2'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ena_r   <= ena;
      busy_r  <= (state_s == ACCUM) || (state_s == DRAIN);
      if (start_s) begin
        bound_r <= bound;
        cnt_r   <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      if (last_s) begin
        drain_r <= 2'd0;
      end else if (state_r == DRAIN) begin
        drain_r <= drain_r + 2'd1;
      end
    end
  end

  // Stage-3 accumulator; once saturated it stays at all-ones for the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (start_s) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (tree_valid_s && !ovf_r) begin
      if (carry_s) begin
        acc_r <= '1;
        ovf_r <= 1'b1;
      end else begin
        acc_r <= ext_s[ACC_W-1:0];
      end
    end
  end

  // Result registers: loaded only on a completed job, so an aborted job
  // leaves the previous result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_r <= 1'b0;
      s_r       <= '0;
      s_ok_r    <= 1'b0;
      s_ovf_r   <= 1'b0;
    end else begin
      s_valid_r <= finish_s;
      if (finish_s) begin
        s_r     <= acc_r;
        s_ovf_r <= ovf_r;
        s_ok_r  <= !ovf_r && (acc_r <= bound_r);
      end
    end
  end

  assign busy    = busy_r;
  assign s_valid = s_valid_r;
  assign s       = s_r;
  assign s_ok    = s_ok_r;
  assign s_ovf   = s_ovf_r;

endmodule

// File: tb/tb_poly_sqnorm_bound.sv
// Scoreboard bench for poly_sqnorm_bound. Four configurations run side by
// side: the default (LOGN=9, LANES=4, NPOLY=2) and three LOGN=10 variants
// with LANES=1, 2 and 8. Each configuration drives the same job list
// (zeros, all +1, all -32768, exact bound, bound+1, abort, two random jobs)
// with random f_valid bubbles; expected results come from a plain
// sum-of-squares model and are checked by a separate monitor.
module tb_poly_sqnorm_bound;

  typedef struct {
    logic [31:0] s;
    logic        ok;
    logic        ovf;
    int          cyc;
  } exp_t;

  localparam int CFG_LOGN  [4] = '{9, 10, 10, 10};
  localparam int CFG_LANES [4] = '{4, 1, 2, 8};
  localparam int CFG_NPOLY [4] = '{2, 2, 1, 2};

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int cfg, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", cfg, name, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int LOGN  = CFG_LOGN[k];
    localparam int LANES = CFG_LANES[k];
    localparam int NPOLY = CFG_NPOLY[k];
    localparam int NC    = NPOLY << LOGN;
    localparam int NB    = NC / LANES;
    localparam longint FBOUND = (LOGN == 9) ? 64'd34034726 : 64'd70265242;

    logic               ena;
    logic               f_valid;
    logic [31:0]        bound;
    logic [LANES*16-1:0] f;
    logic               busy;
    logic               s_valid;
    logic [31:0]        s;
    logic               s_ok;
    logic               s_ovf;

    int          coefs [2048];
    exp_t        exp_q [$];
    logic [31:0] last_s;
    logic        last_ok;
    logic        last_ovf;
    bit          done;

    poly_sqnorm_bound #(
      .LOGN(LOGN), .COEF_W(16), .LANES(LANES), .NPOLY(NPOLY), .ACC_W(32)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .bound   (bound),
      .f_valid (f_valid),
      .f       (f),
      .busy    (busy),
      .s_valid (s_valid),
      .s       (s),
      .s_ok    (s_ok),
      .s_ovf   (s_ovf)
    );

    task automatic garbage();
      for (int j = 0; j < LANES; j++) f[j*16 +: 16] = 16'($urandom);
    endtask

    function automatic longint model_sum();
      longint acc;
      acc = 0;
      for (int i = 0; i < NC; i++) acc += longint'(coefs[i]) * longint'(coefs[i]);
      return acc;
    endfunction

    // Greedy decomposition of the target into squares; alternating signs.
    task automatic fill_exact(input longint target);
      longint r;
      longint c;
      r = target;
      for (int i = 0; i < NC; i++) begin
        c = isqrt(r);
        if (c > 32767) c = 32767;
        r -= c * c;
        coefs[i] = (i % 2 == 1) ? -int'(c) : int'(c);
      end
    endtask

    task automatic fill(input int job);
      case (job)
        0: begin for (int i = 0; i < NC; i++) coefs[i] = 0;      bound = 32'd0; end
        1: begin for (int i = 0; i < NC; i++) coefs[i] = 1;      bound = 32'(FBOUND); end
        2: begin for (int i = 0; i < NC; i++) coefs[i] = -32768; bound = 32'hFFFF_FFFF; end
        3: begin fill_exact(FBOUND); bound = 32'(FBOUND); end
        4: begin fill_exact(FBOUND); coefs[0] = coefs[0] + 1; bound = 32'(FBOUND); end
        5: begin
          for (int i = 0; i < NC; i++) coefs[i] = int'($urandom_range(3000, 0)) - 1500;
          bound = $urandom;
        end
        6: begin
          for (int i = 0; i < NC; i++) coefs[i] = int'($urandom_range(3000, 0)) - 1500;
          bound = 32'(model_sum() - 1 + longint'($urandom_range(2, 0)));
        end
        default: begin
          for (int i = 0; i < NC; i++) coefs[i] = int'($urandom_range(40000, 0)) - 20000;
          bound = $urandom;
        end
      endcase
    endtask

    task automatic run_job(input int abort_at);
      longint sum;
      exp_t   e;
      ena = 1'b1;
      f_valid = 1'b1;
      garbage();
      @(negedge clk);
      chk("busy_after_start", k, 64'(busy), 64'd1);
      for (int b = 0; b < NB; b++) begin
        if (b == abort_at) break;
        while ($urandom_range(3, 0) == 0) begin
          f_valid = 1'b0;
          garbage();
          @(negedge clk);
        end
        f_valid = 1'b1;
        for (int j = 0; j < LANES; j++) f[j*16 +: 16] = 16'(coefs[b*LANES + j]);
        @(negedge clk);
      end
      f_valid = 1'b0;
      if (abort_at >= 0) begin
        ena = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_after_abort", k, 64'(busy), 64'd0);
        chk("s_held", k, 64'(s), 64'(last_s));
        chk("s_ok_held", k, 64'(s_ok), 64'(last_ok));
        chk("s_ovf_held", k, 64'(s_ovf), 64'(last_ovf));
      end else begin
        sum   = model_sum();
        e.ovf = sum > 64'hFFFF_FFFF;
        e.s   = e.ovf ? 32'hFFFF_FFFF : sum[31:0];
        e.ok  = !e.ovf && (e.s <= bound);
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        last_s   = e.s;
        last_ok  = e.ok;
        last_ovf = e.ovf;
        repeat (6) @(negedge clk);
        chk("no_restart_ena_high", k, 64'(busy), 64'd0);
        ena = 1'b0;
        @(negedge clk);
      end
    endtask

    // Monitor: every result strobe must match the oldest expected job.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && s_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_s_valid", k, 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("s", k, 64'(s), 64'(e.s));
            chk("s_ok", k, 64'(s_ok), 64'(e.ok));
            chk("s_ovf", k, 64'(s_ovf), 64'(e.ovf));
            chk("s_valid_cycle", k, 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end

    // Driver: reset checks, then the job list.
    initial begin
      done = 1'b0;
      ena = 1'b0;
      f_valid = 1'b0;
      bound = 32'd0;
      f = '0;
      last_s = 32'd0;
      last_ok = 1'b0;
      last_ovf = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", k, 64'(busy), 64'd0);
      chk("rst_s_valid", k, 64'(s_valid), 64'd0);
      chk("rst_s", k, 64'(s), 64'd0);
      chk("rst_s_ok", k, 64'(s_ok), 64'd0);
      chk("rst_s_ovf", k, 64'(s_ovf), 64'd0);
      wait (rst_n === 1'b1);
      @(negedge clk);
      for (int job = 0; job < 8; job++) begin
        fill(job);
        run_job((job == 5) ? 10 : -1);
      end
      repeat (10) @(negedge clk);
      chk("results_outstanding", k, 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 90000; i++) begin
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) break;
      @(negedge clk);
    end
    chk("all_jobs_finished", -1,
        64'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
